// File: rtl/level_sequencer.sv
// Game-flow controller: owns level_num and lives, and sequences the title, play,
// level-transition, dying, game-over and win phases with registered control outputs.
module level_sequencer #(
    parameter int NUM_LEVELS   = 4,
    parameter int EXIT_X       = 620,
    parameter int PIT_Y        = 470,
    parameter int TRANS_FRAMES = 60,
    parameter int DIE_FRAMES   = 90,
    parameter int START_LIVES  = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic       hit,
    output logic [2:0] level_num,
    output logic [2:0] lives,
    output logic       blank,
    output logic       freeze,
    output logic       respawn,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        TRANS,
        DYING,
        OVER,
        WON
    } state_t;

    localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [2:0] INIT_LIVES = 3'(START_LIVES);
    localparam logic [7:0] TRANS_LAST = 8'(TRANS_FRAMES - 1);
    localparam logic [7:0] DIE_LAST   = 8'(DIE_FRAMES - 1);
    localparam logic [9:0] EXIT_X_C   = 10'(EXIT_X);
    localparam logic [9:0] PIT_Y_C    = 10'(PIT_Y);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] level_q, level_d;
    logic [2:0] lives_q, lives_d;
    logic       start_q;
    logic       blank_q, blank_d;
    logic       freeze_q, freeze_d;
    logic       respawn_q, respawn_d;
    logic       over_q, over_d;
    logic       won_q, won_d;

    logic start_rise;
    logic death;
    logic at_exit;

    // start_q resets high so a button held through reset is not seen as a press
    assign start_rise = start & ~start_q;
    assign death      = hit | (mario_y >= PIT_Y_C);
    assign at_exit    = mario_x >= EXIT_X_C;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        lives_d = lives_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = LOAD;
                    level_d = 3'd0;
                    lives_d = INIT_LIVES;
                end
            end
            LOAD: state_d = PLAY;
            PLAY: begin
                if (frame_tick) begin
                    if (death) begin
                        state_d = DYING;
                        cnt_d   = 8'd0;
                    end else if (at_exit) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d = WON;
                        end else begin
                            state_d = TRANS;
                            level_d = level_q + 3'd1;
                            cnt_d   = 8'd0;
                        end
                    end
                end
            end
            TRANS: begin
                if (frame_tick) begin
                    if (cnt_q == TRANS_LAST) begin
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (cnt_q == DIE_LAST) begin
                        if (lives_q <= 3'd1) begin
                            lives_d = 3'd0;
                            state_d = OVER;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            OVER, WON: begin
                if (start_rise) begin
                    state_d = LOAD;
                    level_d = 3'd0;
                    lives_d = INIT_LIVES;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        blank_d   = 1'b1;
        freeze_d  = 1'b1;
        respawn_d = 1'b0;
        over_d    = 1'b0;
        won_d     = 1'b0;
        case (state_d)
            LOAD: begin
                blank_d   = 1'b0;
                respawn_d = 1'b1;
            end
            PLAY: begin
                blank_d  = 1'b0;
                freeze_d = 1'b0;
            end
            DYING:   blank_d = 1'b0;
            OVER:    over_d  = 1'b1;
            WON:     won_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            level_q   <= 3'd0;
            lives_q   <= INIT_LIVES;
            start_q   <= 1'b1;
            blank_q   <= 1'b1;
            freeze_q  <= 1'b1;
            respawn_q <= 1'b0;
            over_q    <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            start_q   <= start;
            blank_q   <= blank_d;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
            over_q    <= over_d;
            won_q     <= won_d;
        end
    end

    assign level_num = level_q;
    assign lives     = lives_q;
    assign blank     = blank_q;
    assign freeze    = freeze_q;
    assign respawn   = respawn_q;
    assign game_over = over_q;
    assign game_won  = won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: a game-rules model queues the expected
// respawn / game-over / game-won events and a monitor checks each as it appears.
module tb_level_sequencer;

    localparam int NUM_LEVELS   = 4;
    localparam int EXIT_X       = 620;
    localparam int PIT_Y        = 470;
    localparam int TRANS_FRAMES = 60;
    localparam int DIE_FRAMES   = 90;
    localparam int START_LIVES  = 3;

    localparam int EV_RESPAWN = 0;
    localparam int EV_OVER    = 1;
    localparam int EV_WON     = 2;

    typedef struct {
        int kind;
        int level;
        int lives;
        int gap;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick;
    logic       start;
    logic       hit;
    logic [9:0] mario_x;
    logic [9:0] mario_y;
    logic [2:0] level_num;
    logic [2:0] lives;
    logic       blank;
    logic       freeze;
    logic       respawn;
    logic       game_over;
    logic       game_won;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  gen_gap = 0;
    int  m_level = 0;
    int  m_lives = START_LIVES;

    int  mon_ticks = 0;
    int  mon_kind;
    bit  prev_over = 1'b0;
    bit  prev_won = 1'b0;
    bit  ev_r, ev_o, ev_w;
    ev_t mon_e;

    level_sequencer #(
        .NUM_LEVELS  (NUM_LEVELS),
        .EXIT_X      (EXIT_X),
        .PIT_Y       (PIT_Y),
        .TRANS_FRAMES(TRANS_FRAMES),
        .DIE_FRAMES  (DIE_FRAMES),
        .START_LIVES (START_LIVES)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_tick(frame_tick),
        .start     (start),
        .mario_x   (mario_x),
        .mario_y   (mario_y),
        .hit       (hit),
        .level_num (level_num),
        .lives     (lives),
        .blank     (blank),
        .freeze    (freeze),
        .respawn   (respawn),
        .game_over (game_over),
        .game_won  (game_won)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; ticks are tallied so each event knows its expected tick gap
    task automatic applyStimulus(input bit tick, input bit st, input bit h, input logic [9:0] x, input logic [9:0] y);
        frame_tick = tick;
        start      = st;
        hit        = h;
        mario_x    = x;
        mario_y    = y;
        if (tick && Reset_n) gen_gap++;
        @(posedge Clk);
        #1;
    endtask

    task automatic junkCycle(input bit st);
        applyStimulus(1'b0, st, 1'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
    endtask

    task automatic idleGap(input bit st);
        repeat ($urandom_range(2, 0)) junkCycle(st);
    endtask

    task automatic pushEvent(input int kind);
        ev_t e;
        e.kind  = kind;
        e.level = m_level;
        e.lives = m_lives;
        e.gap   = gen_gap;
        gen_gap = 0;
        exp_q.push_back(e);
    endtask

    // Ticks with arbitrary inputs while the game is frozen; start is released before the last one
    task automatic waitTicks(input int n);
        bit st;
        for (int i = 0; i < n; i++) begin
            st = (i < n - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
            idleGap(st);
            applyStimulus(1'b1, st, 1'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
        end
    endtask

    task automatic restartGame();
        repeat ($urandom_range(3, 1))
            applyStimulus(1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
        applyStimulus(1'($urandom_range(1, 0)), 1'b1, 1'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
        m_level = 0;
        m_lives = START_LIVES;
        pushEvent(EV_RESPAWN);
    endtask

    // Plays one life segment until a death or level exit, then applies the game rules
    task automatic playPhase(input bit force_end, input bit fh, input logic [9:0] fx, input logic [9:0] fy, output bit game_end);
        bit         done;
        bit         h;
        bit         die;
        bit         ex;
        logic [9:0] x;
        logic [9:0] y;
        int         safe_ticks;
        done       = 1'b0;
        game_end   = 1'b0;
        safe_ticks = 0;
        junkCycle(1'b0);
        while (!done) begin
            idleGap(1'b0);
            if (force_end && safe_ticks >= 2) begin
                h = fh;
                x = fx;
                y = fy;
            end else if (!force_end && $urandom_range(9, 0) < 3) begin
                h = ($urandom_range(4, 0) == 0);
                x = 10'($urandom_range(1023, 0));
                y = 10'($urandom_range(1023, 0));
            end else begin
                h = 1'b0;
                x = 10'($urandom_range(EXIT_X - 1, 0));
                y = 10'($urandom_range(PIT_Y - 1, 0));
            end
            die = h || (int'(y) >= PIT_Y);
            ex  = int'(x) >= EXIT_X;
            applyStimulus(1'b1, 1'b0, h, x, y);
            safe_ticks++;
            if (die) begin
                checkOutput("dying_freeze", freeze, 1);
                checkOutput("dying_blank", blank, 0);
                checkOutput("dying_level", level_num, m_level);
                checkOutput("dying_lives", lives, m_lives);
                waitTicks(DIE_FRAMES);
                m_lives = m_lives - 1;
                if (m_lives == 0) begin
                    pushEvent(EV_OVER);
                    game_end = 1'b1;
                end else begin
                    pushEvent(EV_RESPAWN);
                end
                done = 1'b1;
            end else if (ex) begin
                if (m_level == NUM_LEVELS - 1) begin
                    pushEvent(EV_WON);
                    game_end = 1'b1;
                end else begin
                    m_level++;
                    checkOutput("exit_level", level_num, m_level);
                    checkOutput("exit_blank", blank, 1);
                    checkOutput("exit_freeze", freeze, 1);
                    waitTicks(TRANS_FRAMES);
                    pushEvent(EV_RESPAWN);
                end
                done = 1'b1;
            end else if (safe_ticks == 1) begin
                checkOutput("play_blank", blank, 0);
                checkOutput("play_freeze", freeze, 0);
            end
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_level", level_num, 0);
        checkOutput("rst_lives", lives, START_LIVES);
        checkOutput("rst_blank", blank, 1);
        checkOutput("rst_freeze", freeze, 1);
        checkOutput("rst_respawn", respawn, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_game_won", game_won, 0);
    endtask

    // Monitor: every respawn pulse or rising game_over/game_won edge consumes one expected event
    always @(negedge Clk) begin
        if (!Reset_n) begin
            mon_ticks = 0;
            prev_over = 1'b0;
            prev_won  = 1'b0;
        end else begin
            ev_r = (respawn === 1'b1);
            ev_o = (game_over === 1'b1) && !prev_over;
            ev_w = (game_won === 1'b1) && !prev_won;
            if (ev_r || ev_o || ev_w) begin
                mon_kind = ev_r ? EV_RESPAWN : (ev_o ? EV_OVER : EV_WON);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", mon_kind);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_kind", mon_kind, mon_e.kind);
                    checkOutput("event_tick_gap", mon_ticks, mon_e.gap);
                    checkOutput("event_level", level_num, mon_e.level);
                    checkOutput("event_lives", lives, mon_e.lives);
                    checkOutput("event_blank", blank, (mon_e.kind == EV_RESPAWN) ? 0 : 1);
                    checkOutput("event_freeze", freeze, 1);
                    checkOutput("event_respawn", respawn, (mon_e.kind == EV_RESPAWN) ? 1 : 0);
                    checkOutput("event_game_over", game_over, (mon_e.kind == EV_OVER) ? 1 : 0);
                    checkOutput("event_game_won", game_won, (mon_e.kind == EV_WON) ? 1 : 0);
                end
                mon_ticks = 0;
            end
            prev_over = game_over;
            prev_won  = game_won;
            if (frame_tick === 1'b1) mon_ticks++;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit game_end;
        frame_tick = 1'b0;
        start      = 1'b0;
        hit        = 1'b0;
        mario_x    = 10'd0;
        mario_y    = 10'd0;
        repeat (3) @(posedge Clk);
        #1;
        checkResetValues();
        Reset_n = 1'b1;

        $display("[TB] start, exit at boundary, death beats exit");
        restartGame();
        playPhase(1'b1, 1'b0, 10'd620, 10'd100, game_end);
        playPhase(1'b1, 1'b0, 10'd630, 10'd475, game_end);

        $display("[TB] hit deaths to game over, then restart");
        game_end = 1'b0;
        while (!game_end) playPhase(1'b1, 1'b1, 10'd100, 10'd200, game_end);
        restartGame();

        $display("[TB] exit through every level to win");
        game_end = 1'b0;
        while (!game_end) playPhase(1'b1, 1'b0, 10'(EXIT_X + $urandom_range(40, 0)), 10'(PIT_Y - 1), game_end);
        restartGame();

        $display("[TB] randomized games");
        for (int g = 0; g < 4; g++) begin
            game_end = 1'b0;
            while (!game_end) playPhase(1'b0, 1'b0, 10'd0, 10'd0, game_end);
            restartGame();
        end

        $display("[TB] reset in the middle of a transition with start held");
        junkCycle(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd100, 10'd100);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd700, 10'd100);
        waitTicks(30);
        start   = 1'b1;
        Reset_n = 1'b0;
        #1;
        checkResetValues();
        gen_gap = 0;
        m_level = 0;
        m_lives = START_LIVES;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (8)
            applyStimulus(1'($urandom_range(1, 0)), 1'b1, 1'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
        checkOutput("held_start_blank", blank, 1);
        checkOutput("held_start_respawn", respawn, 0);
        checkOutput("held_start_freeze", freeze, 1);
        restartGame();
        game_end = 1'b0;
        while (!game_end) playPhase(1'b0, 1'b0, 10'd0, 10'd0, game_end);

        repeat (5) junkCycle(1'b0);
        checkOutput("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
